// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared constants and types for the iterative divider.
//   state_t        : divider FSM states (IDLE, DIV0, BUSY, FIX, DONE)
//   DivStart/Stop  : start_i levels
//   DivResultReady/NotReady : ready_o levels
//   RstEnable      : active level of the synchronous reset
package div_iter_pkg;

    typedef enum logic [2:0] {
        DivFree,    // IDLE: waiting for start_i
        DivByZero,  // DIV0: divisor was zero, report in one cycle
        DivOn,      // BUSY: one quotient bit per clock
        DivFix,     // FIX: sign correction and result write
        DivEnd      // DONE: hold result until start_i drops
    } state_t;

    localparam logic DivStart         = 1'b1;
    localparam logic DivStop          = 1'b0;
    localparam logic DivResultReady   = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic RstEnable        = 1'b1;

endpackage

// File: rtl/div_iter_if.sv
// div_iter_if: request/response bundle between the execute stage and the
// divider.
//   signed_div_i, opdata1_i, opdata2_i, start_i, annul_i : requester -> divider
//   result_o ({remainder, quotient}), ready_o, div0_o, busy_o : divider -> requester
// master : requester side (pipeline / testbench)
// slave  : divider side
interface div_iter_if #(
    parameter int WIDTH = 24
) ();
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 div0_o;
    logic                 busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, div0_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, div0_o, busy_o
    );
endinterface

// File: rtl/div_abs_neg.sv
// div_abs_neg: combinational conditional two's-complement negate.
//   value  : WIDTH-bit input
//   neg    : 1 = output -value, 0 = output value unchanged
//   result : WIDTH-bit output
// Used both to take operand magnitudes and to apply the final sign fix-up.
module div_abs_neg #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);
    always_comb begin
        result = value;
        if (neg) begin
            result = (~value) + WIDTH'(1);
        end
    end
endmodule

// File: rtl/div_iter.sv
// div_iter: radix-2 restoring divider, one quotient bit per clock.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : div_iter_if.slave
//          signed_div_i/opdata1_i/opdata2_i sampled at accept,
//          start_i level request, annul_i abort (BUSY/FIX only),
//          result_o = {remainder, quotient}, ready_o result valid,
//          div0_o divisor was zero, busy_o high outside IDLE.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic        clk,
    input logic        rst,
    div_iter_if.slave  bus
);

    state_t state, state_next;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   dq;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   rem;       // partial remainder
    logic [WIDTH-1:0]   divisor;   // divisor magnitude
    logic               neg_quo;   // quotient needs negation at fix-up
    logic               neg_rem;   // remainder needs negation at fix-up
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;
    logic               div0_q;

    logic [WIDTH-1:0]   mag1, mag2, quo_fix, rem_fix;
    logic [WIDTH:0]     shifted, trial;
    logic               accept;
    logic               last_iter;

    div_abs_neg #(.WIDTH(WIDTH)) u_mag1 (
        .value  (bus.opdata1_i),
        .neg    (bus.signed_div_i & bus.opdata1_i[WIDTH-1]),
        .result (mag1)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_mag2 (
        .value  (bus.opdata2_i),
        .neg    (bus.signed_div_i & bus.opdata2_i[WIDTH-1]),
        .result (mag2)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
        .value  (dq),
        .neg    (neg_quo),
        .result (quo_fix)
    );

    // Also restores the raw dividend for the divide-by-zero report, since
    // rem holds the dividend magnitude in that case.
    div_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (rem),
        .neg    (neg_rem),
        .result (rem_fix)
    );

    // The full partial remainder is shifted (not rem[WIDTH-2:0]) so that
    // unsigned divisors with the MSB set still divide correctly.
    assign shifted   = {rem, dq[WIDTH-1]};
    assign trial     = shifted - {1'b0, divisor};
    assign accept    = (bus.start_i == DivStart) && !bus.annul_i;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state <= DivFree;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DivFree: begin
                if (accept) begin
                    state_next = (mag2 == '0) ? DivByZero : DivOn;
                end
            end
            DivOn: begin
                if (bus.annul_i) begin
                    state_next = DivFree;
                end else if (last_iter) begin
                    state_next = DivFix;
                end
            end
            DivFix: begin
                state_next = bus.annul_i ? DivFree : DivEnd;
            end
            DivByZero: begin
                state_next = DivEnd;
            end
            DivEnd: begin
                if (bus.start_i == DivStop) begin
                    state_next = DivFree;
                end
            end
            default: begin
                state_next = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt      <= '0;
            dq       <= '0;
            rem      <= '0;
            divisor  <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
            div0_q   <= 1'b0;
        end else begin
            case (state)
                DivFree: begin
                    if (accept) begin
                        neg_quo <= bus.signed_div_i &
                                   (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                        neg_rem <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
                        divisor <= mag2;
                        dq      <= mag1;
                        cnt     <= '0;
                        rem     <= (mag2 == '0) ? mag1 : '0;
                    end
                end
                DivOn: begin
                    if (trial[WIDTH]) begin
                        rem <= shifted[WIDTH-1:0];
                        dq  <= {dq[WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= trial[WIDTH-1:0];
                        dq  <= {dq[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                DivFix: begin
                    if (!bus.annul_i) begin
                        result_q <= {rem_fix, quo_fix};
                        ready_q  <= DivResultReady;
                    end
                end
                DivByZero: begin
                    result_q <= {rem_fix, {WIDTH{1'b1}}};
                    div0_q   <= 1'b1;
                    ready_q  <= DivResultReady;
                end
                DivEnd: begin
                    if (bus.start_i == DivStop) begin
                        result_q <= '0;
                        ready_q  <= DivResultNotReady;
                        div0_q   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign bus.div0_o   = div0_q;
    assign bus.busy_o   = (state != DivFree);

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: scoreboard bench for div_iter. The driver issues divisions
// and pushes the arithmetic reference result; a monitor pops and compares
// on every rising ready_o.
module tb_div_iter;
    localparam int W = 24;

    typedef struct {
        logic [W-1:0] rem;
        logic [W-1:0] quo;
        logic         div0;
        int           lat;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    logic ready_prev = 1'b0;

    div_iter_if #(.WIDTH(W)) bus ();

    div_iter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb, q, r;
        if (b == '0) begin
            e.rem  = a;
            e.quo  = '1;
            e.div0 = 1'b1;
            e.lat  = 1;
        end else begin
            if (s) begin
                sa = $signed(a);
                sb = $signed(b);
            end else begin
                sa = {40'd0, a};
                sb = {40'd0, b};
            end
            q = sa / sb;
            r = sa % sb;
            e.rem  = r[W-1:0];
            e.quo  = q[W-1:0];
            e.div0 = 1'b0;
            e.lat  = W + 1;
        end
        e.acc = 0;
        return e;
    endfunction

    // Monitor: one pop per rising ready_o.
    always @(negedge clk) begin
        if (bus.ready_o && !ready_prev) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ready", 128'(bus.ready_o), 128'(0));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("quotient", 128'(bus.result_o[W-1:0]), 128'(e.quo));
                chk("remainder", 128'(bus.result_o[2*W-1:W]), 128'(e.rem));
                chk("div0", 128'(bus.div0_o), 128'(e.div0));
                chk("latency", 128'(cyc - e.acc), 128'(e.lat));
            end
        end
        ready_prev = bus.ready_o;
    end

    // Called at a negedge with the divider idle.
    task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t             e;
        logic [2*W-1:0]   held;
        bit               seen;
        e = model(s, a, b);
        e.acc = cyc + 1;
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        // Operands must already be latched.
        bus.signed_div_i = ~s;
        bus.opdata1_i    = W'($urandom);
        bus.opdata2_i    = W'($urandom);
        seen = 1'b0;
        held = '0;
        for (int i = 0; i < W + 10; i++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                seen = 1'b1;
                held = bus.result_o;
                break;
            end
        end
        if (!seen) begin
            chk("ready_timeout", 128'(0), 128'(1));
        end else begin
            repeat (2) @(negedge clk);
            chk("hold_ready", 128'(bus.ready_o), 128'(1));
            chk("hold_result", 128'(bus.result_o), 128'(held));
            chk("busy_done", 128'(bus.busy_o), 128'(1));
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        chk("idle_ready", 128'(bus.ready_o), 128'(0));
        chk("idle_result", 128'(bus.result_o), 128'(0));
        chk("idle_div0", 128'(bus.div0_o), 128'(0));
        chk("idle_busy", 128'(bus.busy_o), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic         s;
        logic [W-1:0] a, b;

        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_result", 128'(bus.result_o), 128'(0));
        chk("rst_ready", 128'(bus.ready_o), 128'(0));
        chk("rst_div0", 128'(bus.div0_o), 128'(0));
        chk("rst_busy", 128'(bus.busy_o), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        run_div(1'b0, W'(100), W'(7));
        run_div(1'b1, W'(-100), W'(7));
        run_div(1'b1, W'(100), W'(-7));
        run_div(1'b0, W'(5), W'(0));
        run_div(1'b1, W'(-5), W'(0));
        run_div(1'b1, 24'h800000, 24'hFFFFFF);
        run_div(1'b0, 24'h800000, 24'hFFFFFF);
        run_div(1'b0, 24'hFFFFFF, 24'h800001);
        run_div(1'b1, 24'h800000, 24'h000001);

        // Abort after 10 BUSY cycles.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = W'(1000);
        bus.opdata2_i    = W'(3);
        bus.start_i      = 1'b1;
        repeat (11) @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        chk("annul_busy", 128'(bus.busy_o), 128'(0));
        chk("annul_ready", 128'(bus.ready_o), 128'(0));
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("annul_ready_later", 128'(bus.ready_o), 128'(0));
        run_div(1'b0, W'(9), W'(3));

        // Reset in the middle of a division.
        bus.signed_div_i = 1'b1;
        bus.opdata1_i    = W'(-12345);
        bus.opdata2_i    = W'(17);
        bus.start_i      = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_result", 128'(bus.result_o), 128'(0));
        chk("midrst_ready", 128'(bus.ready_o), 128'(0));
        chk("midrst_div0", 128'(bus.div0_o), 128'(0));
        chk("midrst_busy", 128'(bus.busy_o), 128'(0));
        rst = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = W'($urandom);
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 20));
                2:       b = W'(-$urandom_range(1, 20));
                default: b = W'($urandom);
            endcase
            run_div(s, a, b);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
